// File: rtl/zigbee_fifo_apb_arbiter_pkg.sv
// Shared types and defaults for the Zigbee FIFO APB arbiter: FSM state,
// transfer owner and default parameter values.
package zigbee_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef enum logic {
    OWN_TX = 1'b0,
    OWN_RX = 1'b1
  } owner_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/zigbee_fifo_apb_arbiter_if.sv
// Requester handshakes plus the shared APB master port. The master modport is
// the arbiter's view; the slave modport is the view of everything around it.
interface zigbee_fifo_apb_arbiter_if
  import zigbee_apb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              tx_valid_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_ready_o;
  logic              tx_done_o;
  logic              tx_err_o;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_done_o;
  logic              rx_err_o;
  logic              psel_tx_o;
  logic              psel_rx_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              pslverr_i;
  logic              timeout_o;

  modport master (
    input  tx_valid_i, tx_data_i, rx_valid_i, prdata_i, pready_i, pslverr_i,
    output tx_ready_o, tx_done_o, tx_err_o, rx_ready_o, rx_data_o, rx_done_o,
           rx_err_o, psel_tx_o, psel_rx_o, penable_o, pwrite_o, pwdata_o,
           timeout_o
  );

  modport slave (
    output tx_valid_i, tx_data_i, rx_valid_i, prdata_i, pready_i, pslverr_i,
    input  tx_ready_o, tx_done_o, tx_err_o, rx_ready_o, rx_data_o, rx_done_o,
           rx_err_o, psel_tx_o, psel_rx_o, penable_o, pwrite_o, pwdata_o,
           timeout_o
  );

endinterface

// File: rtl/zigbee_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, last owner updated
// on accept. The requester other than the last owner is preferred when idle.
module zigbee_rr_arb2
  import zigbee_apb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   tx_req,
  input  logic   rx_req,
  output logic   tx_gnt,
  output logic   rx_gnt,
  output logic   accept,
  output owner_e owner
);

  owner_e last_owner;
  owner_e pick;

  always_comb begin
    pick = (last_owner == OWN_RX) ? OWN_TX : OWN_RX;
    if (tx_req && !rx_req) begin
      pick = OWN_TX;
    end else if (rx_req && !tx_req) begin
      pick = OWN_RX;
    end
  end

  assign tx_gnt = en && (pick == OWN_TX);
  assign rx_gnt = en && (pick == OWN_RX);
  assign accept = (tx_gnt && tx_req) || (rx_gnt && rx_req);
  assign owner  = pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_RX;
    end else if (accept) begin
      last_owner <= pick;
    end
  end

endmodule

// File: rtl/zigbee_fifo_apb_arbiter.sv
// Shares one APB master port between the FIFO Tx writer and FIFO Rx reader.
// Define ZIGBEE_ARB_TIMEOUT_EN to abort ACCESS phases that stall too long.
//
// state  | meaning
// IDLE   | no select active, ready offered to one requester
// SETUP  | psel of owner high, penable low
// ACCESS | psel and penable high, waiting for pready (or timeout)
module zigbee_fifo_apb_arbiter
  import zigbee_apb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                       clk_i,
  input logic                       reset_i,
  zigbee_fifo_apb_arbiter_if.master bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("zigbee_fifo_apb_arbiter: TIMEOUT must be within 2..255");
  end

  state_e            state_q, state_n;
  owner_e            owner_q, owner_n;
  owner_e            grant_owner;
  logic              accept;
  logic              tx_gnt, rx_gnt;
  logic              expired;
  logic              resp_err;
  logic [DATA_W-1:0] pwdata_q, pwdata_n;
  logic [DATA_W-1:0] rx_data_q, rx_data_n;
  logic              pwrite_q, pwrite_n;
  logic              psel_tx_q, psel_rx_q, penable_q;
  logic              tx_done_q, tx_done_n, tx_err_q, tx_err_n;
  logic              rx_done_q, rx_done_n, rx_err_q, rx_err_n;

  zigbee_rr_arb2 u_arb (
    .clk    (clk_i),
    .reset  (reset_i),
    .en     (state_q == IDLE),
    .tx_req (bus.tx_valid_i),
    .rx_req (bus.rx_valid_i),
    .tx_gnt (tx_gnt),
    .rx_gnt (rx_gnt),
    .accept (accept),
    .owner  (grant_owner)
  );

`ifdef ZIGBEE_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q;
  logic       timeout_q;

  // pready on the expiry cycle takes priority, so expiry requires pready low
  assign expired = (state_q == ACCESS) && !bus.pready_i && (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= expired;
      if (state_q == SETUP) begin
        wait_cnt_q <= 8'd0;
      end else if (state_q == ACCESS && !bus.pready_i) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign expired       = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_n   = state_q;
    owner_n   = owner_q;
    pwdata_n  = pwdata_q;
    pwrite_n  = pwrite_q;
    rx_data_n = rx_data_q;
    tx_done_n = 1'b0;
    tx_err_n  = 1'b0;
    rx_done_n = 1'b0;
    rx_err_n  = 1'b0;
    resp_err  = bus.pready_i ? bus.pslverr_i : 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n  = SETUP;
          owner_n  = grant_owner;
          pwrite_n = (grant_owner == OWN_TX);
          pwdata_n = bus.tx_data_i;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (bus.pready_i || expired) begin
          state_n = IDLE;
          if (owner_q == OWN_TX) begin
            tx_done_n = 1'b1;
            tx_err_n  = resp_err;
          end else begin
            rx_done_n = 1'b1;
            rx_err_n  = resp_err;
            if (bus.pready_i) begin
              rx_data_n = bus.prdata_i;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      owner_q   <= OWN_TX;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rx_data_q <= '0;
      psel_tx_q <= 1'b0;
      psel_rx_q <= 1'b0;
      penable_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      owner_q   <= owner_n;
      pwdata_q  <= pwdata_n;
      pwrite_q  <= pwrite_n;
      rx_data_q <= rx_data_n;
      psel_tx_q <= (state_n != IDLE) && (owner_n == OWN_TX);
      psel_rx_q <= (state_n != IDLE) && (owner_n == OWN_RX);
      penable_q <= (state_n == ACCESS);
      tx_done_q <= tx_done_n;
      tx_err_q  <= tx_err_n;
      rx_done_q <= rx_done_n;
      rx_err_q  <= rx_err_n;
    end
  end

  assign bus.tx_ready_o = tx_gnt;
  assign bus.rx_ready_o = rx_gnt;
  assign bus.psel_tx_o  = psel_tx_q;
  assign bus.psel_rx_o  = psel_rx_q;
  assign bus.penable_o  = penable_q;
  assign bus.pwrite_o   = pwrite_q;
  assign bus.pwdata_o   = pwdata_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.tx_done_o  = tx_done_q;
  assign bus.tx_err_o   = tx_err_q;
  assign bus.rx_done_o  = rx_done_q;
  assign bus.rx_err_o   = rx_err_q;

endmodule

// File: tb/tb_zigbee_fifo_apb_arbiter.sv
// Bench for zigbee_fifo_apb_arbiter: cycle-level reference model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_zigbee_fifo_apb_arbiter;

  localparam int TO = 4;
`ifdef ZIGBEE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zigbee_fifo_apb_arbiter_if #(.DATA_W(8)) bus ();

  zigbee_fifo_apb_arbiter #(.DATA_W(8), .TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state: transfer phase is the cycle count since accept.
  bit         m_valid = 1'b0;
  bit         m_active, m_owner_rx, m_last_rx, m_pw;
  int         m_k;
  logic [7:0] m_pwdata, m_rx_data;
  bit         m_txd, m_txe, m_rxd, m_rxe, m_to;

  initial begin
    bit tv, rv, e_txr, e_rxr, err, to;
    forever begin
      @(negedge clk);
      tv = bus.tx_valid_i;
      rv = bus.rx_valid_i;
      if (m_valid) begin
        chk("ready_excl", bus.tx_ready_o & bus.rx_ready_o, 0);
        if (m_active) begin
          chk("tx_ready_busy", bus.tx_ready_o, 0);
          chk("rx_ready_busy", bus.rx_ready_o, 0);
        end else if (tv || rv) begin
          e_txr = tv && (!rv || m_last_rx);
          e_rxr = rv && (!tv || !m_last_rx);
          chk("tx_ready", bus.tx_ready_o, e_txr);
          chk("rx_ready", bus.rx_ready_o, e_rxr);
        end
        chk("psel_tx", bus.psel_tx_o, m_active && !m_owner_rx);
        chk("psel_rx", bus.psel_rx_o, m_active && m_owner_rx);
        chk("penable", bus.penable_o, m_active && m_k >= 2);
        chk("pwrite", bus.pwrite_o, m_pw);
        chk("pwdata", bus.pwdata_o, m_pwdata);
        chk("tx_done", bus.tx_done_o, m_txd);
        chk("tx_err", bus.tx_err_o, m_txe);
        chk("rx_done", bus.rx_done_o, m_rxd);
        chk("rx_err", bus.rx_err_o, m_rxe);
        chk("rx_data", bus.rx_data_o, m_rx_data);
        chk("timeout", bus.timeout_o, m_to);
      end
      if (reset) begin
        m_valid = 1'b1; m_active = 1'b0; m_owner_rx = 1'b0; m_last_rx = 1'b1;
        m_pw = 1'b0; m_pwdata = 8'h00; m_rx_data = 8'h00; m_k = 0;
        m_txd = 0; m_txe = 0; m_rxd = 0; m_rxe = 0; m_to = 0;
      end else if (m_valid) begin
        m_txd = 0; m_txe = 0; m_rxd = 0; m_rxe = 0; m_to = 0;
        if (m_active) begin
          err = 1'b0; to = 1'b0;
          if (m_k >= 2 && bus.pready_i) begin
            m_active = 1'b0; err = bus.pslverr_i;
            if (m_owner_rx) m_rx_data = bus.prdata_i;
          end else if (TO_EN && m_k >= 2 && (m_k - 2) == TO - 1) begin
            m_active = 1'b0; err = 1'b1; to = 1'b1;
          end else begin
            m_k++;
          end
          if (!m_active) begin
            m_to = to;
            if (m_owner_rx) begin m_rxd = 1; m_rxe = err; end
            else begin m_txd = 1; m_txe = err; end
          end
        end else if (tv || rv) begin
          m_owner_rx = (tv && rv) ? !m_last_rx : rv;
          m_last_rx  = m_owner_rx;
          m_active   = 1'b1;
          m_k        = 1;
          m_pw       = !m_owner_rx;
          m_pwdata   = bus.tx_data_i;
        end
      end
    end
  end

  // Directed scenarios: per-cycle capture starting at the accept cycle.
  bit         pr_sched [16];
  bit         rst_sched[16];
  logic       cap_txr[16], cap_rxr[16], cap_pst[16], cap_psr[16], cap_pen[16];
  logic       cap_pw[16], cap_txd[16], cap_txe[16], cap_rxd[16], cap_rxe[16], cap_to[16];
  logic [7:0] cap_pwd[16], cap_rxdat[16];

  task automatic set_sched(input int first_ready, input int rst_at);
    for (int i = 0; i < 16; i++) begin
      pr_sched[i]  = (i >= first_ready);
      rst_sched[i] = (i == rst_at);
    end
  endtask

  task automatic capture(input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      bus.pready_i = pr_sched[i];
      reset        = rst_sched[i];
      @(negedge clk);
      cap_txr[i] = bus.tx_ready_o;  cap_rxr[i] = bus.rx_ready_o;
      cap_pst[i] = bus.psel_tx_o;   cap_psr[i] = bus.psel_rx_o;
      cap_pen[i] = bus.penable_o;   cap_pw[i]  = bus.pwrite_o;
      cap_pwd[i] = bus.pwdata_o;    cap_rxdat[i] = bus.rx_data_o;
      cap_txd[i] = bus.tx_done_o;   cap_txe[i] = bus.tx_err_o;
      cap_rxd[i] = bus.rx_done_o;   cap_rxe[i] = bus.rx_err_o;
      cap_to[i]  = bus.timeout_o;
      @(posedge clk); #1;
      if (drop && i == 0) begin
        bus.tx_valid_i = 1'b0;
        bus.rx_valid_i = 1'b0;
      end
    end
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.pready_i = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic any;
    reset = 1'b1;
    bus.tx_valid_i = 0; bus.rx_valid_i = 0; bus.tx_data_i = 8'h00;
    bus.prdata_i = 8'h00; bus.pready_i = 0; bus.pslverr_i = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_psel_tx", bus.psel_tx_o, 0);
    chk("rst_penable", bus.penable_o, 0);
    chk("rst_rx_data", bus.rx_data_o, 8'h00);
    chk("rst_pwrite", bus.pwrite_o, 0);
    @(posedge clk); #1;

    // Tx only, no wait states
    set_sched(0, -1);
    bus.tx_data_i = 8'hA5; bus.tx_valid_i = 1'b1;
    capture(8, 1'b1);
    chk("t1_ready", cap_txr[0], 1);
    chk("t1_psel_n1", cap_pst[1], 1);
    chk("t1_pen_n1", cap_pen[1], 0);
    chk("t1_psel_n2", cap_pst[2], 1);
    chk("t1_pen_n2", cap_pen[2], 1);
    chk("t1_pwdata", cap_pwd[2], 8'hA5);
    chk("t1_pwrite", cap_pw[1], 1);
    chk("t1_done_n2", cap_txd[2], 0);
    chk("t1_done_n3", cap_txd[3], 1);
    chk("t1_err_n3", cap_txe[3], 0);
    chk("t1_psel_n3", cap_pst[3], 0);
    idle(2);

    // Rx with two wait states
    set_sched(4, -1);
    bus.prdata_i = 8'h3C; bus.rx_valid_i = 1'b1;
    capture(8, 1'b1);
    any = 1'b0;
    for (int i = 0; i < 8; i++) any = any | cap_pst[i];
    chk("t2_psel_tx_never", any, 0);
    chk("t2_psel_rx_n1", cap_psr[1], 1);
    chk("t2_psel_rx_n4", cap_psr[4], 1);
    chk("t2_pwrite", cap_pw[2], 0);
    chk("t2_done_n4", cap_rxd[4], 0);
    chk("t2_done_n5", cap_rxd[5], 1);
    chk("t2_err_n5", cap_rxe[5], 0);
    chk("t2_data_n5", cap_rxdat[5], 8'h3C);
    chk("t2_data_hold", cap_rxdat[7], 8'h3C);
    idle(2);

`ifdef ZIGBEE_ARB_TIMEOUT_EN
    // Rx with pready stuck low aborts at accept+6
    set_sched(16, -1);
    bus.prdata_i = 8'h77; bus.rx_valid_i = 1'b1;
    capture(9, 1'b1);
    chk("to_done_n5", cap_rxd[5], 0);
    chk("to_done_n6", cap_rxd[6], 1);
    chk("to_err_n6", cap_rxe[6], 1);
    chk("to_flag_n6", cap_to[6], 1);
    chk("to_data_kept", cap_rxdat[6], 8'h3C);
    chk("to_psel_n5", cap_psr[5], 1);
    chk("to_psel_n6", cap_psr[6], 0);
    idle(2);
`endif

    // Tx with slave error
    set_sched(0, -1);
    bus.pslverr_i = 1'b1; bus.tx_data_i = 8'h5A; bus.tx_valid_i = 1'b1;
    capture(6, 1'b1);
    chk("t3_pwdata", cap_pwd[1], 8'h5A);
    chk("t3_done_n3", cap_txd[3], 1);
    chk("t3_err_n3", cap_txe[3], 1);
    chk("t3_timeout_n3", cap_to[3], 0);
    bus.pslverr_i = 1'b0;
    idle(2);

    // Reset while in ACCESS
    set_sched(16, 3);
    bus.tx_data_i = 8'hC3; bus.tx_valid_i = 1'b1;
    capture(8, 1'b1);
    chk("t5_pen_n3", cap_pen[3], 1);
    chk("t5_psel_n4", cap_pst[4], 0);
    chk("t5_pen_n4", cap_pen[4], 0);
    any = 1'b0;
    for (int i = 4; i < 8; i++) any = any | cap_txd[i] | cap_rxd[i];
    chk("t5_no_done", any, 0);

    // Both valid held continuously after reset: TX, RX, TX, RX
    set_sched(0, -1);
    bus.tx_data_i = 8'h11; bus.tx_valid_i = 1'b1; bus.rx_valid_i = 1'b1;
    bus.prdata_i = 8'h96;
    capture(13, 1'b0);
    bus.tx_valid_i = 1'b0; bus.rx_valid_i = 1'b0;
    chk("t4_g0_tx", cap_txr[0], 1);
    chk("t4_g1_rx", cap_rxr[3], 1);
    chk("t4_g2_tx", cap_txr[6], 1);
    chk("t4_g3_rx", cap_rxr[9], 1);
    chk("t4_txdone_n3", cap_txd[3], 1);
    chk("t4_rxdone_n6", cap_rxd[6], 1);
    chk("t4_rxdata_n6", cap_rxdat[6], 8'h96);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
